// File: rtl/snes_sram_sequencer_if.sv
// Bus bundle between the address decoder / MCU side and the SRAM0 sequencer.
interface snes_sram_sequencer_if;
  logic        SNES_RD_STROBE;
  logic        SNES_WR_STROBE;
  logic [23:0] ROM_ADDR;
  logic        ROM_HIT;
  logic        IS_WRITABLE;
  logic [7:0]  SNES_DIN;
  logic [7:0]  SNES_DOUT;
  logic        SNES_DOUT_VALID;
  logic        MCU_RRQ;
  logic        MCU_WRQ;
  logic [23:0] MCU_ADDR;
  logic [7:0]  MCU_DOUT;
  logic [7:0]  MCU_DIN;
  logic        MCU_RDY;
  logic [22:0] RAM_A;
  logic [15:0] RAM_DOUT;
  logic [15:0] RAM_DIN;
  logic        RAM_DOE;
  logic        RAM_OE_N;
  logic        RAM_WE_N;
  logic        RAM_CE_N;
  logic        RAM_BHE_N;
  logic        RAM_BLE_N;

  modport slave (
    input  SNES_RD_STROBE, SNES_WR_STROBE, ROM_ADDR, ROM_HIT, IS_WRITABLE, SNES_DIN,
    input  MCU_RRQ, MCU_WRQ, MCU_ADDR, MCU_DOUT, RAM_DIN,
    output SNES_DOUT, SNES_DOUT_VALID, MCU_DIN, MCU_RDY,
    output RAM_A, RAM_DOUT, RAM_DOE, RAM_OE_N, RAM_WE_N, RAM_CE_N, RAM_BHE_N, RAM_BLE_N
  );

  modport master (
    output SNES_RD_STROBE, SNES_WR_STROBE, ROM_ADDR, ROM_HIT, IS_WRITABLE, SNES_DIN,
    output MCU_RRQ, MCU_WRQ, MCU_ADDR, MCU_DOUT, RAM_DIN,
    input  SNES_DOUT, SNES_DOUT_VALID, MCU_DIN, MCU_RDY,
    input  RAM_A, RAM_DOUT, RAM_DOE, RAM_OE_N, RAM_WE_N, RAM_CE_N, RAM_BHE_N, RAM_BLE_N
  );
endinterface

// File: rtl/snes_sram_sequencer.sv
// Timed SRAM0 access sequencer: serves SNES bus cycles first and slots MCU
// requests into the idle gaps between them.
module snes_sram_sequencer #(
  parameter int unsigned RD_CYCLES = 4,
  parameter int unsigned WR_CYCLES = 3,
  parameter int unsigned IDLE_GAP  = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  snes_sram_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_SRD, S_SWR, S_MRD, S_MWR, S_GAP} state_e;

  localparam logic [3:0] RD_LAST  = 4'(RD_CYCLES - 1);
  localparam logic [3:0] WR_LAST  = 4'(WR_CYCLES);  // index of the hold clock
  localparam logic [3:0] GAP_LAST = 4'((IDLE_GAP == 0) ? 0 : IDLE_GAP - 1);
  localparam state_e     POST_ACC = (IDLE_GAP == 0) ? S_IDLE : S_GAP;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        snes_rd_pend_q, snes_rd_pend_d, snes_wr_pend_q, snes_wr_pend_d;
  logic        mcu_pend_q, mcu_pend_d, mcu_wr_q, mcu_wr_d, mcu_rdy_q, mcu_rdy_d;
  logic [23:0] snes_rd_addr_q, snes_rd_addr_d, snes_wr_addr_q, snes_wr_addr_d;
  logic [23:0] mcu_addr_q, mcu_addr_d;
  logic [7:0]  snes_wr_data_q, snes_wr_data_d, mcu_wdata_q, mcu_wdata_d;

  logic        a0_q, a0_d;
  logic [22:0] ram_a_q, ram_a_d;
  logic [15:0] ram_dout_q, ram_dout_d;
  logic        ram_doe_q, ram_doe_d, ram_oe_n_q, ram_oe_n_d, ram_we_n_q, ram_we_n_d;
  logic        ram_ce_n_q, ram_ce_n_d, ram_bhe_n_q, ram_bhe_n_d, ram_ble_n_q, ram_ble_n_d;
  logic [7:0]  snes_dout_q, snes_dout_d, mcu_din_q, mcu_din_d;
  logic        snes_valid_q, snes_valid_d;

  logic        entering_c, rd_done_c, wr_done_c, is_rd_c, is_wr_c, wr_act_c;
  logic [23:0] sel_addr_c;
  logic [7:0]  sel_data_c, rd_byte_c;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rd_done_c = (cnt_q == RD_LAST);
  assign wr_done_c = (cnt_q == WR_LAST);

  // Next-state: fixed-priority arbitration in IDLE, per-state clock counting
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 4'd1;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = 4'd0;
        if      (snes_rd_pend_q) state_d = S_SRD;
        else if (snes_wr_pend_q) state_d = S_SWR;
        else if (mcu_pend_q)     state_d = mcu_wr_q ? S_MWR : S_MRD;
      end
      S_SRD, S_MRD: if (rd_done_c) begin state_d = POST_ACC; cnt_d = 4'd0; end
      S_SWR, S_MWR: if (wr_done_c) begin state_d = POST_ACC; cnt_d = 4'd0; end
      S_GAP:        if (cnt_q == GAP_LAST) begin state_d = S_IDLE; cnt_d = 4'd0; end
      default: begin state_d = S_IDLE; cnt_d = 4'd0; end
    endcase
  end

  assign entering_c = (state_q == S_IDLE) && (state_d != S_IDLE);
  assign sel_addr_c = (state_d == S_SRD) ? snes_rd_addr_q :
                      (state_d == S_SWR) ? snes_wr_addr_q : mcu_addr_q;
  assign sel_data_c = (state_d == S_SWR) ? snes_wr_data_q : mcu_wdata_q;
  assign rd_byte_c  = a0_q ? bus.RAM_DIN[15:8] : bus.RAM_DIN[7:0];

  // Outputs: strobes derived from the upcoming state so they change on entry
  always_comb begin
    a0_d       = a0_q;
    ram_a_d    = ram_a_q;
    ram_dout_d = ram_dout_q;
    if (entering_c) begin
      a0_d    = sel_addr_c[0];
      ram_a_d = sel_addr_c[23:1];
      if (state_d == S_SWR || state_d == S_MWR) ram_dout_d = {sel_data_c, sel_data_c};
    end
    is_rd_c     = (state_d == S_SRD) || (state_d == S_MRD);
    is_wr_c     = (state_d == S_SWR) || (state_d == S_MWR);
    wr_act_c    = is_wr_c && (cnt_d < WR_LAST);
    ram_oe_n_d  = !is_rd_c;
    ram_we_n_d  = !wr_act_c;
    ram_ce_n_d  = !(is_rd_c || wr_act_c);
    ram_doe_d   = is_wr_c;
    ram_bhe_n_d = !(is_rd_c || (wr_act_c && a0_d));
    ram_ble_n_d = !(is_rd_c || (wr_act_c && !a0_d));

    snes_dout_d  = snes_dout_q;
    snes_valid_d = 1'b0;
    mcu_din_d    = mcu_din_q;
    if (state_q == S_SRD && rd_done_c) begin
      snes_dout_d  = rd_byte_c;
      snes_valid_d = 1'b1;
    end
    if (state_q == S_MRD && rd_done_c) mcu_din_d = rd_byte_c;
  end

  // Request capture; a strobe in the decision clock re-arms the flag being served
  always_comb begin
    snes_rd_pend_d = snes_rd_pend_q;
    snes_wr_pend_d = snes_wr_pend_q;
    mcu_pend_d     = mcu_pend_q;
    mcu_wr_d       = mcu_wr_q;
    mcu_rdy_d      = mcu_rdy_q;
    snes_rd_addr_d = snes_rd_addr_q;
    snes_wr_addr_d = snes_wr_addr_q;
    snes_wr_data_d = snes_wr_data_q;
    mcu_addr_d     = mcu_addr_q;
    mcu_wdata_d    = mcu_wdata_q;
    if (entering_c && state_d == S_SRD) snes_rd_pend_d = 1'b0;
    if (entering_c && state_d == S_SWR) snes_wr_pend_d = 1'b0;
    if (entering_c && (state_d == S_MRD || state_d == S_MWR)) mcu_pend_d = 1'b0;
    if ((state_q == S_MRD && rd_done_c) || (state_q == S_MWR && wr_done_c)) mcu_rdy_d = 1'b1;
    if (bus.SNES_RD_STROBE && bus.ROM_HIT) begin
      snes_rd_pend_d = 1'b1;
      snes_rd_addr_d = bus.ROM_ADDR;
    end
    if (bus.SNES_WR_STROBE && bus.ROM_HIT && bus.IS_WRITABLE) begin
      snes_wr_pend_d = 1'b1;
      snes_wr_addr_d = bus.ROM_ADDR;
      snes_wr_data_d = bus.SNES_DIN;
    end
    if ((bus.MCU_RRQ || bus.MCU_WRQ) && mcu_rdy_q) begin
      mcu_pend_d  = 1'b1;
      mcu_wr_d    = bus.MCU_WRQ && !bus.MCU_RRQ;
      mcu_rdy_d   = 1'b0;
      mcu_addr_d  = bus.MCU_ADDR;
      mcu_wdata_d = bus.MCU_DOUT;
    end
  end

  // Registered outputs and request latches
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      snes_rd_pend_q <= 1'b0;
      snes_wr_pend_q <= 1'b0;
      mcu_pend_q     <= 1'b0;
      mcu_wr_q       <= 1'b0;
      mcu_rdy_q      <= 1'b1;
      snes_rd_addr_q <= 24'd0;
      snes_wr_addr_q <= 24'd0;
      snes_wr_data_q <= 8'd0;
      mcu_addr_q     <= 24'd0;
      mcu_wdata_q    <= 8'd0;
      a0_q           <= 1'b0;
      ram_a_q        <= 23'd0;
      ram_dout_q     <= 16'd0;
      ram_doe_q      <= 1'b0;
      ram_oe_n_q     <= 1'b1;
      ram_we_n_q     <= 1'b1;
      ram_ce_n_q     <= 1'b1;
      ram_bhe_n_q    <= 1'b1;
      ram_ble_n_q    <= 1'b1;
      snes_dout_q    <= 8'd0;
      snes_valid_q   <= 1'b0;
      mcu_din_q      <= 8'd0;
    end else begin
      snes_rd_pend_q <= snes_rd_pend_d;
      snes_wr_pend_q <= snes_wr_pend_d;
      mcu_pend_q     <= mcu_pend_d;
      mcu_wr_q       <= mcu_wr_d;
      mcu_rdy_q      <= mcu_rdy_d;
      snes_rd_addr_q <= snes_rd_addr_d;
      snes_wr_addr_q <= snes_wr_addr_d;
      snes_wr_data_q <= snes_wr_data_d;
      mcu_addr_q     <= mcu_addr_d;
      mcu_wdata_q    <= mcu_wdata_d;
      a0_q           <= a0_d;
      ram_a_q        <= ram_a_d;
      ram_dout_q     <= ram_dout_d;
      ram_doe_q      <= ram_doe_d;
      ram_oe_n_q     <= ram_oe_n_d;
      ram_we_n_q     <= ram_we_n_d;
      ram_ce_n_q     <= ram_ce_n_d;
      ram_bhe_n_q    <= ram_bhe_n_d;
      ram_ble_n_q    <= ram_ble_n_d;
      snes_dout_q    <= snes_dout_d;
      snes_valid_q   <= snes_valid_d;
      mcu_din_q      <= mcu_din_d;
    end
  end

  assign bus.SNES_DOUT       = snes_dout_q;
  assign bus.SNES_DOUT_VALID = snes_valid_q;
  assign bus.MCU_DIN         = mcu_din_q;
  assign bus.MCU_RDY         = mcu_rdy_q;
  assign bus.RAM_A           = ram_a_q;
  assign bus.RAM_DOUT        = ram_dout_q;
  assign bus.RAM_DOE         = ram_doe_q;
  assign bus.RAM_OE_N        = ram_oe_n_q;
  assign bus.RAM_WE_N        = ram_we_n_q;
  assign bus.RAM_CE_N        = ram_ce_n_q;
  assign bus.RAM_BHE_N       = ram_bhe_n_q;
  assign bus.RAM_BLE_N       = ram_ble_n_q;

endmodule

// File: tb/tb_snes_sram_sequencer.sv
// Directed bench for snes_sram_sequencer with default timing parameters.
module tb_snes_sram_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snes_sram_sequencer_if bus();

  snes_sram_sequencer #(.RD_CYCLES(4), .WR_CYCLES(3), .IDLE_GAP(1)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Access log entries are {is_write, RAM_A} captured when CE_N falls
  logic [23:0] acc_log [$];
  logic        ce_prev = 1'b1;
  int          valid_cnt = 0;
  int          we_cnt = 0;
  int          oe_cnt = 0;

  always @(negedge clk) begin
    if (!bus.RAM_CE_N && ce_prev) acc_log.push_back({!bus.RAM_WE_N, bus.RAM_A});
    ce_prev   <= bus.RAM_CE_N;
    valid_cnt <= valid_cnt + (bus.SNES_DOUT_VALID ? 1 : 0);
    we_cnt    <= we_cnt + (bus.RAM_WE_N ? 0 : 1);
    oe_cnt    <= oe_cnt + (bus.RAM_OE_N ? 0 : 1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin tick(); n++; end while (!bus.SNES_DOUT_VALID && n < 40);
  endtask

  task automatic wait_rdy(output int n);
    n = 0;
    while (!bus.MCU_RDY && n < 60) begin tick(); n++; end
  endtask

  task automatic settle();
    repeat (8) tick();
  endtask

  int n, base, v0, w0, o0;

  initial begin
    bus.SNES_RD_STROBE = 1'b0; bus.SNES_WR_STROBE = 1'b0;
    bus.ROM_ADDR = 24'd0; bus.ROM_HIT = 1'b0; bus.IS_WRITABLE = 1'b0; bus.SNES_DIN = 8'd0;
    bus.MCU_RRQ = 1'b0; bus.MCU_WRQ = 1'b0; bus.MCU_ADDR = 24'd0; bus.MCU_DOUT = 8'd0;
    bus.RAM_DIN = 16'd0;
    repeat (3) tick();
    check("rst_strobes", 32'({bus.RAM_CE_N, bus.RAM_OE_N, bus.RAM_WE_N, bus.RAM_BHE_N, bus.RAM_BLE_N}), 32'h1F);
    check("rst_doe", 32'(bus.RAM_DOE), 32'd0);
    check("rst_ram_a", 32'(bus.RAM_A), 32'd0);
    check("rst_dout", 32'({bus.RAM_DOUT, bus.SNES_DOUT, bus.MCU_DIN}), 32'd0);
    check("rst_valid_rdy", 32'({bus.SNES_DOUT_VALID, bus.MCU_RDY}), 32'b01);
    rst_n = 1'b1;
    tick();

    // Idle SNES read
    o0 = oe_cnt;
    bus.ROM_ADDR = 24'h000101; bus.ROM_HIT = 1'b1; bus.RAM_DIN = 16'hA55A;
    bus.SNES_RD_STROBE = 1'b1; tick(); bus.SNES_RD_STROBE = 1'b0;
    tick(); n = 1;
    check("rd_ram_a", 32'(bus.RAM_A), 32'h000080);
    check("rd_strobes", 32'({bus.RAM_CE_N, bus.RAM_OE_N, bus.RAM_WE_N, bus.RAM_BHE_N, bus.RAM_BLE_N}), 32'b00100);
    while (!bus.SNES_DOUT_VALID && n < 40) begin tick(); n++; end
    check("rd_latency", 32'(n), 32'd5);
    check("rd_dout", 32'(bus.SNES_DOUT), 32'hA5);
    tick();
    check("rd_valid_pulse", 32'(bus.SNES_DOUT_VALID), 32'd0);
    check("rd_oe_n", 32'(bus.RAM_OE_N), 32'd1);
    settle();
    check("rd_oe_cycles", 32'(oe_cnt - o0), 32'd4);

    // Write gated off by IS_WRITABLE=0
    base = acc_log.size(); w0 = we_cnt;
    bus.ROM_ADDR = 24'hE00000; bus.SNES_DIN = 8'h3C; bus.IS_WRITABLE = 1'b0;
    bus.SNES_WR_STROBE = 1'b1; tick(); bus.SNES_WR_STROBE = 1'b0;
    settle();
    check("wr_gated_we", 32'(we_cnt - w0), 32'd0);
    check("wr_gated_acc", 32'(acc_log.size() - base), 32'd0);

    // Permitted write
    bus.IS_WRITABLE = 1'b1;
    bus.SNES_WR_STROBE = 1'b1; tick(); bus.SNES_WR_STROBE = 1'b0;
    tick();
    check("wr_ram_a", 32'(bus.RAM_A), 32'h700000);
    check("wr_strobes", 32'({bus.RAM_CE_N, bus.RAM_OE_N, bus.RAM_WE_N, bus.RAM_BHE_N, bus.RAM_BLE_N}), 32'b01010);
    check("wr_data", 32'({bus.RAM_DOE, bus.RAM_DOUT}), 32'h13C3C);
    tick(); tick();
    check("wr_we_last", 32'(bus.RAM_WE_N), 32'd0);
    tick();
    check("wr_hold", 32'({bus.RAM_WE_N, bus.RAM_DOE, bus.RAM_DOUT}), 32'h33C3C);
    check("wr_hold_a", 32'(bus.RAM_A), 32'h700000);
    tick();
    check("wr_doe_off", 32'(bus.RAM_DOE), 32'd0);
    settle();
    check("wr_we_cycles", 32'(we_cnt - w0), 32'd3);

    // MCU read followed one clock later by a SNES read
    base = acc_log.size(); v0 = valid_cnt;
    bus.MCU_ADDR = 24'h000010; bus.RAM_DIN = 16'h1234;
    bus.MCU_RRQ = 1'b1; tick(); bus.MCU_RRQ = 1'b0;
    bus.ROM_ADDR = 24'h000203; bus.SNES_RD_STROBE = 1'b1; tick(); bus.SNES_RD_STROBE = 1'b0;
    check("col_rdy_low", 32'(bus.MCU_RDY), 32'd0);
    wait_rdy(n);
    check("col_mcu_din", 32'(bus.MCU_DIN), 32'h34);
    check("col_no_valid_yet", 32'(valid_cnt - v0), 32'd0);
    bus.RAM_DIN = 16'hBEEF;
    wait_valid(n);
    check("col_gap_latency", 32'(n), 32'd6);
    check("col_snes_dout", 32'(bus.SNES_DOUT), 32'hBE);
    settle();
    check("col_acc_count", 32'(acc_log.size() - base), 32'd2);
    if (acc_log.size() >= base + 2) begin
      check("col_first_mrd", 32'(acc_log[base]), 32'h000008);
      check("col_then_srd", 32'(acc_log[base + 1]), 32'h000101);
    end

    // Three requests pending while a SNES write is in flight
    base = acc_log.size();
    bus.RAM_DIN = 16'h5AC3;
    bus.ROM_ADDR = 24'h000400; bus.SNES_DIN = 8'h11;
    bus.SNES_WR_STROBE = 1'b1; tick(); bus.SNES_WR_STROBE = 1'b0;
    tick();
    bus.ROM_ADDR = 24'h000500; bus.SNES_RD_STROBE = 1'b1; tick(); bus.SNES_RD_STROBE = 1'b0;
    bus.ROM_ADDR = 24'h000600; bus.SNES_DIN = 8'h22;
    bus.SNES_WR_STROBE = 1'b1; tick(); bus.SNES_WR_STROBE = 1'b0;
    bus.MCU_ADDR = 24'h000700; bus.MCU_RRQ = 1'b1; tick(); bus.MCU_RRQ = 1'b0;
    wait_rdy(n);
    check("pend_rdy_timeout", 32'(n < 60), 32'd1);
    check("pend_mcu_din", 32'(bus.MCU_DIN), 32'hC3);
    settle();
    check("pend_acc_count", 32'(acc_log.size() - base), 32'd4);
    if (acc_log.size() >= base + 4) begin
      check("pend_0_swr", 32'(acc_log[base]), 32'h800200);
      check("pend_1_srd", 32'(acc_log[base + 1]), 32'h000280);
      check("pend_2_swr", 32'(acc_log[base + 2]), 32'h800300);
      check("pend_3_mrd", 32'(acc_log[base + 3]), 32'h000380);
    end

    // Latest SNES read wins; MCU pulse while busy is ignored
    base = acc_log.size(); w0 = we_cnt;
    bus.MCU_ADDR = 24'h000020; bus.MCU_RRQ = 1'b1; tick(); bus.MCU_RRQ = 1'b0;
    bus.ROM_ADDR = 24'h000800; bus.SNES_RD_STROBE = 1'b1; tick();
    bus.ROM_ADDR = 24'h000900; tick(); bus.SNES_RD_STROBE = 1'b0;
    bus.MCU_ADDR = 24'h000030; bus.MCU_WRQ = 1'b1; tick(); bus.MCU_WRQ = 1'b0;
    wait_rdy(n);
    wait_valid(n);
    check("latest_valid", 32'(bus.SNES_DOUT_VALID), 32'd1);
    settle(); settle();
    check("latest_acc_count", 32'(acc_log.size() - base), 32'd2);
    check("busy_mcu_ignored", 32'(we_cnt - w0), 32'd0);
    if (acc_log.size() >= base + 2)
      check("latest_addr", 32'(acc_log[base + 1]), 32'h000480);

    // Read with ROM_HIT=0
    base = acc_log.size(); v0 = valid_cnt;
    bus.ROM_HIT = 1'b0; bus.ROM_ADDR = 24'h001000;
    bus.SNES_RD_STROBE = 1'b1; tick(); bus.SNES_RD_STROBE = 1'b0;
    settle();
    check("miss_no_ce", 32'(acc_log.size() - base), 32'd0);
    check("miss_no_valid", 32'(valid_cnt - v0), 32'd0);
    bus.ROM_HIT = 1'b1;

    // Reset during a WE_N-low clock of an MCU write
    bus.MCU_ADDR = 24'h000011; bus.MCU_DOUT = 8'h77;
    bus.MCU_WRQ = 1'b1; tick(); bus.MCU_WRQ = 1'b0;
    tick();
    check("mwr_strobes", 32'({bus.RAM_CE_N, bus.RAM_WE_N, bus.RAM_BHE_N, bus.RAM_BLE_N}), 32'b0001);
    check("mwr_data", 32'({bus.RAM_DOUT, bus.MCU_RDY}), 32'({16'h7777, 1'b0}));
    tick();
    rst_n = 1'b0; #1;
    check("rst_mid_we", 32'({bus.RAM_WE_N, bus.RAM_CE_N, bus.RAM_DOE}), 32'b110);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_rel_rdy", 32'(bus.MCU_RDY), 32'd1);
    check("rst_rel_ce", 32'(bus.RAM_CE_N), 32'd1);

    // Top-of-space address, read then write
    bus.ROM_ADDR = 24'hFFFFFF; bus.RAM_DIN = 16'hC001;
    bus.SNES_RD_STROBE = 1'b1; tick(); bus.SNES_RD_STROBE = 1'b0;
    wait_valid(n);
    check("top_rd_latency", 32'(n), 32'd5);
    check("top_rd_dout", 32'(bus.SNES_DOUT), 32'hC0);
    check("top_ram_a", 32'(bus.RAM_A), 32'h7FFFFF);
    settle();
    bus.SNES_DIN = 8'h5E;
    bus.SNES_WR_STROBE = 1'b1; tick(); bus.SNES_WR_STROBE = 1'b0;
    tick();
    check("top_wr_lanes", 32'({bus.RAM_WE_N, bus.RAM_BHE_N, bus.RAM_BLE_N}), 32'b001);
    check("top_wr_a", 32'(bus.RAM_A), 32'h7FFFFF);
    settle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
